// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed response latency
// Optional misaligned-access checking is compiled in with DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [1:0]  op,
   input  logic [19:0] tag,
   input  logic [5:0]  index,
   input  logic [5:0]  offset,
   input  logic [3:0]  write_type,
   input  logic [31:0] w_data_CPU,
   output logic        addr_valid,
   output logic        data_valid,
   output logic [31:0] r_data_CPU,
   output logic        err
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        lat_wr;
   logic [31:0] lat_addr;
   logic [3:0]  lat_wt;
   logic [31:0] lat_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [1:0]    boff;
   logic [3:0]    wt_norm;
   logic [31:0]   width_mask;
   logic [3:0]    be;
   logic [31:0]   wdata_sh;
   logic [31:0]   load_data;
   logic          misalign;
   logic          unused_bits;

   // Upper address bits beyond the array wrap away; op[1] carries no meaning here.
   assign unused_bits = ^{op[1], lat_addr[31:AW+2]};

   assign word_idx = lat_addr[AW+1:2];
   assign boff     = lat_addr[1:0];

   always_comb begin
      wt_norm    = 4'b1111;
      width_mask = 32'hFFFF_FFFF;
      case (lat_wt)
         4'b0001: begin
            wt_norm    = 4'b0001;
            width_mask = 32'h0000_00FF;
         end
         4'b0011: begin
            wt_norm    = 4'b0011;
            width_mask = 32'h0000_FFFF;
         end
         default: begin
            wt_norm    = 4'b1111;
            width_mask = 32'hFFFF_FFFF;
         end
      endcase
   end

   // Lanes shifted past byte 3 fall off the top on stores and read back as zero on loads.
   assign be        = wt_norm << boff;
   assign wdata_sh  = lat_wdata << {boff, 3'b000};
   assign load_data = (mem[word_idx] >> {boff, 3'b000}) & width_mask;

`ifdef DMEM_MISALIGN_CHK_EN
   assign misalign = ((wt_norm == 4'b0011) && boff[0]) ||
                     ((wt_norm == 4'b1111) && (boff != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         lat_wr    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wt    <= 4'd0;
         lat_wdata <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (valid) begin
                  lat_wr    <= op[0];
                  lat_addr  <= {tag, index, offset};
                  lat_wt    <= write_type;
                  lat_wdata <= w_data_CPU;
                  cnt       <= 4'(LATENCY - 1);
               end
            end
            S_WAIT:  cnt <= cnt - 4'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (valid) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (cnt == 4'd1) state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      addr_valid = 1'b0;
      data_valid = 1'b0;
      r_data_CPU = 32'd0;
      err        = 1'b0;
      if (state == S_IDLE && valid && !rst) addr_valid = 1'b1;
      if (state == S_RESP) begin
         data_valid = 1'b1;
         err        = misalign;
         if (!lat_wr && !misalign) r_data_CPU = load_data;
      end
   end

   // Commit on the RESP edge; a reset landing on that edge abandons the store.
   always_ff @(posedge clk) begin
      if (!rst && state == S_RESP && lat_wr && !misalign) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
// Expectations follow DMEM_MISALIGN_CHK_EN when it is defined for the build.
module tb_dmem_responder;
   localparam int LAT = 2;

`ifdef DMEM_MISALIGN_CHK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [1:0]  op;
   logic [19:0] tag;
   logic [5:0]  index;
   logic [5:0]  offset;
   logic [3:0]  write_type;
   logic [31:0] w_data_CPU;
   logic        addr_valid;
   logic        data_valid;
   logic [31:0] r_data_CPU;
   logic        err;

   typedef struct packed {
      logic [31:0] r;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   last_dv = 0;
   int   dv_a;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .valid(valid), .op(op), .tag(tag), .index(index),
      .offset(offset), .write_type(write_type), .w_data_CPU(w_data_CPU),
      .addr_valid(addr_valid), .data_valid(data_valid), .r_data_CPU(r_data_CPU), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before timeout");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic req(input bit w, input logic [31:0] a, input logic [3:0] wt, input logic [31:0] wd);
      valid      = 1'b1;
      op         = {1'b0, w};
      {tag, index, offset} = a;
      write_type = wt;
      w_data_CPU = wd;
   endtask

   task automatic run_txn(input string name, input bit scramble,
                          input logic [31:0] exp_r, input logic exp_e);
      bit   seen;
      exp_t ent;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         @(negedge clk);
         if (addr_valid) seen = 1'b1;
      end
      chk({name, "_accept"}, 32'(seen), 32'd1);
      last_acc = cyc;
      ent.r = exp_r;
      ent.e = exp_e;
      exp_q.push_back(ent);
      if (scramble) begin
         @(posedge clk);
         #1;
         valid      = 1'b0;
         tag        = 20'($urandom);
         offset     = 6'($urandom);
         write_type = 4'($urandom);
         op         = 2'b01;
         w_data_CPU = $urandom;
      end
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (data_valid) seen = 1'b1;
         else begin
            chk({name, "_busy_av"}, 32'(addr_valid), 32'd0);
            chk({name, "_busy_rdata"}, r_data_CPU, 32'd0);
         end
      end
      chk({name, "_dv"}, 32'(seen), 32'd1);
      chk({name, "_lat"}, 32'(cyc - last_acc), 32'(LAT));
      last_dv = cyc;
      if (seen && exp_q.size() > 0) begin
         ent = exp_q.pop_front();
         chk({name, "_rdata"}, r_data_CPU, ent.r);
         chk({name, "_err"}, 32'(err), 32'(ent.e));
      end
   endtask

   task automatic txn(input string name, input bit w, input logic [31:0] a, input logic [3:0] wt,
                      input logic [31:0] wd, input logic [31:0] exp_r, input logic exp_e);
      @(posedge clk);
      #1;
      req(w, a, wt, wd);
      run_txn(name, 1'b0, exp_r, exp_e);
      valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      valid = 1'b0;
      op = 2'b00;
      tag = '0;
      index = '0;
      offset = '0;
      write_type = 4'b1111;
      w_data_CPU = '0;
      repeat (2) @(negedge clk);
      chk("rst_av", 32'(addr_valid), 32'd0);
      chk("rst_dv", 32'(data_valid), 32'd0);
      chk("rst_rdata", r_data_CPU, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      valid = 1'b1;
      #1;
      chk("rst_av_forced", 32'(addr_valid), 32'd0);
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      txn("wr_word", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
      txn("rd_word", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);

      txn("wr_base", 1'b1, 32'h10, 4'b1111, 32'h11223344, 32'h0, 1'b0);
      txn("wr_byte", 1'b1, 32'h13, 4'b0001, 32'h000000AA, 32'h0, 1'b0);
      txn("rd_merged", 1'b0, 32'h10, 4'b1111, 32'h0, 32'hAA223344, 1'b0);
      txn("rd_half", 1'b0, 32'h12, 4'b0011, 32'h0, 32'h0000AA22, 1'b0);
      txn("rd_byte", 1'b0, 32'h11, 4'b0001, 32'h0, 32'h00000033, 1'b0);
      txn("rd_odd_wt", 1'b0, 32'h10, 4'b0101, 32'h0, 32'hAA223344, 1'b0);

      txn("wr_zero", 1'b1, 32'h0, 4'b1111, 32'h5A5A5A5A, 32'h0, 1'b0);
      txn("rd_wrap", 1'b0, 32'h1000, 4'b1111, 32'h0, 32'h5A5A5A5A, 1'b0);

      // Valid held high across two requests; the second must land the cycle after RESP.
      @(posedge clk);
      #1;
      req(1'b1, 32'h30, 4'b1111, 32'hCAFEF00D);
      run_txn("b2b_a", 1'b0, 32'h0, 1'b0);
      dv_a = last_dv;
      req(1'b0, 32'h30, 4'b1111, 32'h0);
      run_txn("b2b_b", 1'b0, 32'hCAFEF00D, 1'b0);
      chk("b2b_gap", 32'(last_acc - dv_a), 32'd1);
      valid = 1'b0;

      @(posedge clk);
      #1;
      req(1'b0, 32'h10, 4'b1111, 32'h0);
      run_txn("scramble", 1'b1, 32'hAA223344, 1'b0);
      valid = 1'b0;

      txn("wr_pre", 1'b1, 32'h20, 4'b1111, 32'h01020304, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      req(1'b1, 32'h20, 4'b1111, 32'hFFFFFFFF);
      @(negedge clk);
      chk("abort_accept", 32'(addr_valid), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort_dv", 32'(data_valid), 32'd0);
         chk("abort_av", 32'(addr_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_post_dv", 32'(data_valid), 32'd0);
      end
      txn("rd_after_abort", 1'b0, 32'h20, 4'b1111, 32'h0, 32'h01020304, 1'b0);

      txn("wr_mis", 1'b1, 32'h22, 4'b1111, 32'h55667788, 32'h0, MIS);
      txn("rd_after_mis", 1'b0, 32'h20, 4'b1111, 32'h0, MIS ? 32'h01020304 : 32'h77880304, 1'b0);
      txn("rd_mis", 1'b0, 32'h22, 4'b1111, 32'h0, MIS ? 32'h0 : 32'h00007788, MIS);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
